// File: rtl/riscv_br_pkg.sv
// Shared constants and types for branch resolution and the BHT.
// Imported by the table, the top level and its interface users.
package riscv_br_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [1:0] PCSRC_SEQ     = 2'b00;
  localparam logic [1:0] PCSRC_TGT     = 2'b01;
  localparam logic [1:0] PCSRC_JALR    = 2'b10;
  localparam logic [1:0] PCSRC_RECOVER = 2'b11;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef logic state_t;
  localparam state_t INIT = 1'b0;
  localparam state_t RUN  = 1'b1;

  function automatic logic [1:0] sat_update(
    input logic [1:0] c,
    input logic       up
  );
    logic [1:0] r;
    r = c;
    case (c)
      SNT:     r = up ? WNT : SNT;
      WNT:     r = up ? WT  : SNT;
      WT:      r = up ? ST  : WNT;
      default: r = up ? ST  : WT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve_bht_if.sv
// Pipeline-facing bundle of the branch resolution unit.
// master = pipeline/hazard side, slave = resolution unit.
interface branch_resolve_bht_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  pc_d;
  logic             pred_taken_d;
  logic             busy;
  logic [XLEN-1:0]  pc_e;
  logic             branch_e;
  logic             jump_e;
  logic             jalr_e;
  logic             stall_e;
  logic [2:0]       func3_e;
  logic             zero_e;
  logic             lt_e;
  logic             ltu_e;
  logic             pred_taken_e;
  logic [1:0]       pc_src;
  logic             flush_de;
  logic             illegal_br;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output pc_d, pc_e, branch_e, jump_e, jalr_e,
    output stall_e, func3_e, zero_e, lt_e, ltu_e,
    output pred_taken_e,
    input  pred_taken_d, busy, pc_src, flush_de,
    input  illegal_br, branch_cnt, mispred_cnt
  );

  modport slave (
    input  pc_d, pc_e, branch_e, jump_e, jalr_e,
    input  stall_e, func3_e, zero_e, lt_e, ltu_e,
    input  pred_taken_e,
    output pred_taken_d, busy, pc_src, flush_de,
    output illegal_br, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/bht_counter_table.sv
// Table of 2-bit saturating counters: async read, sync write.
// A write either initialises an entry or steps it up/down.
module bht_counter_table
  import riscv_br_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IW     = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic [IW-1:0] rd_idx,
  output logic [1:0]    rd_cnt,
  input  logic          wr_en,
  input  logic          wr_init,
  input  logic          wr_taken,
  input  logic [IW-1:0] wr_idx
);

  logic [1:0] bht_q [ENTRIES];
  logic [1:0] bht_d [ENTRIES];

  // next table contents: one entry written per cycle at most
  always_comb begin
    bht_d = bht_q;
    if (wr_en) begin
      bht_d[wr_idx] = wr_init ? WNT
                    : sat_update(bht_q[wr_idx], wr_taken);
    end
  end

  // table storage; contents are set by the init sweep, no reset
  always_ff @(posedge clk) begin
    bht_q <= bht_d;
  end

  assign rd_cnt = bht_q[rd_idx];

endmodule

// File: rtl/branch_resolve_bht.sv
// Branch resolution with BHT prediction, table init sweep
// and branch / mispredict performance counters.
module branch_resolve_bht
  import riscv_br_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_LSB     = 2,
  parameter int CNT_W       = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_resolve_bht_if.slave  bus
);

  localparam int IW = $clog2(BHT_ENTRIES);

  logic [XLEN-1:0]  pc_d;
  logic [XLEN-1:0]  pc_e;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    upd_idx;
  logic [1:0]       rd_cnt;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic             taken;
  logic             legal;
  logic             init_wr;
  logic             train;
  logic [1:0]       pc_src;
  logic             unused_pc;

  assign pc_d      = bus.pc_d;
  assign pc_e      = bus.pc_e;
  assign rd_idx    = pc_d[IDX_LSB +: IW];
  assign upd_idx   = pc_e[IDX_LSB +: IW];
  assign unused_pc = ^{pc_d, pc_e};

  // branch condition decode from func3 and ALU flags
  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (bus.func3_e)
      BEQ:     taken = bus.zero_e;
      BNE:     taken = ~bus.zero_e;
      BLT:     taken = bus.lt_e;
      BGE:     taken = ~bus.lt_e;
      BLTU:    taken = bus.ltu_e;
      BGEU:    taken = ~bus.ltu_e;
      default: legal = 1'b0;
    endcase
  end

  // next-PC source, jalr first, then jal, then mispredicts
  always_comb begin
    pc_src = PCSRC_SEQ;
    if (bus.jalr_e)
      pc_src = PCSRC_JALR;
    else if (bus.jump_e)
      pc_src = PCSRC_TGT;
    else if (bus.branch_e && taken && !bus.pred_taken_e)
      pc_src = PCSRC_TGT;
    else if (bus.branch_e && !taken && bus.pred_taken_e)
      pc_src = PCSRC_RECOVER;
  end

  assign init_wr = (state_q == INIT);
  assign train   = (state_q == RUN) && bus.branch_e
                 && !bus.stall_e && legal;

  // init sweep sequencing and performance counting
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (state_q == INIT) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == IW'(BHT_ENTRIES - 1))
        state_d = RUN;
    end
    if (train) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
      if (taken != bus.pred_taken_e)
        mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  // state, init index and counters with sync reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= INIT;
      idx_q         <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  bht_counter_table #(
    .ENTRIES (BHT_ENTRIES)
  ) u_table (
    .clk      (clk),
    .rd_idx   (rd_idx),
    .rd_cnt   (rd_cnt),
    .wr_en    (init_wr || train),
    .wr_init  (init_wr),
    .wr_taken (taken),
    .wr_idx   (init_wr ? idx_q : upd_idx)
  );

  assign bus.pred_taken_d = (state_q == RUN) && rd_cnt[1];
  assign bus.busy         = (state_q == INIT);
  assign bus.pc_src       = pc_src;
  assign bus.flush_de     = (pc_src != PCSRC_SEQ);
  assign bus.illegal_br   = bus.branch_e && !legal;
  assign bus.branch_cnt   = branch_cnt_q;
  assign bus.mispred_cnt  = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht with a per-cycle
// reference model and hand-computed literal checkpoints.
module tb_branch_resolve_bht;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  branch_resolve_bht_if bus();

  branch_resolve_bht dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_bht [64];
  bit m_valid;
  bit m_busy;
  int m_init;
  int unsigned m_br;
  int unsigned m_mis;

  function automatic bit m_taken(input logic [2:0] f,
                                 input bit z, l, lu);
    case (f)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return l;
      3'd5:    return !l;
      3'd6:    return lu;
      3'd7:    return !lu;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_legal(input logic [2:0] f);
    return !(f == 3'd2 || f == 3'd3);
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  always @(posedge clk) begin
    bit t;
    int k;
    if (!rst_n) begin
      m_valid = 1;
      m_busy  = 1;
      m_init  = 0;
      m_br    = 0;
      m_mis   = 0;
    end else if (m_busy) begin
      m_bht[m_init] = 1;
      m_init++;
      if (m_init == 64) m_busy = 0;
    end else if (bus.branch_e && !bus.stall_e
                 && m_legal(bus.func3_e)) begin
      t = m_taken(bus.func3_e, bus.zero_e,
                  bus.lt_e, bus.ltu_e);
      k = m_idx(bus.pc_e);
      if (t && m_bht[k] < 3) m_bht[k]++;
      if (!t && m_bht[k] > 0) m_bht[k]--;
      m_br++;
      if (t != bus.pred_taken_e) m_mis++;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    bit t;
    bit lg;
    logic [1:0] ps;
    bit pd;
    if (m_valid) begin
      lg = m_legal(bus.func3_e);
      t  = m_taken(bus.func3_e, bus.zero_e,
                   bus.lt_e, bus.ltu_e);
      if (bus.jalr_e) ps = 2'b10;
      else if (bus.jump_e) ps = 2'b01;
      else if (bus.branch_e && t && !bus.pred_taken_e)
        ps = 2'b01;
      else if (bus.branch_e && !t && bus.pred_taken_e)
        ps = 2'b11;
      else ps = 2'b00;
      pd = m_busy ? 1'b0 : (m_bht[m_idx(bus.pc_d)] >= 2);
      chk("m_pc_src", 32'(bus.pc_src), 32'(ps));
      chk("m_flush", 32'(bus.flush_de), 32'(ps != 0));
      chk("m_illegal", 32'(bus.illegal_br),
          32'(bus.branch_e && !lg));
      chk("m_busy", 32'(bus.busy), 32'(m_busy));
      chk("m_pred", 32'(bus.pred_taken_d), 32'(pd));
      chk("m_brcnt", bus.branch_cnt, m_br);
      chk("m_miscnt", bus.mispred_cnt, m_mis);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.branch_e     = 0;
    bus.jump_e       = 0;
    bus.jalr_e       = 0;
    bus.stall_e      = 0;
    bus.func3_e      = 3'd0;
    bus.zero_e       = 0;
    bus.lt_e         = 0;
    bus.ltu_e        = 0;
    bus.pred_taken_e = 0;
  endtask

  task automatic br(input logic [2:0] f, input bit z,
                    input bit l, input bit lu, input bit p,
                    input logic [31:0] pc);
    idle();
    bus.branch_e     = 1;
    bus.func3_e      = f;
    bus.zero_e       = z;
    bus.lt_e         = l;
    bus.ltu_e        = lu;
    bus.pred_taken_e = p;
    bus.pc_e         = pc;
  endtask

  task automatic busy_len(input string nm);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      n++;
    end
    chk(nm, n, 64);
  endtask

  typedef struct {
    logic [2:0] f;
    bit z, l, lu;
    bit tk;
  } vec_t;

  vec_t vecs[8];

  initial begin
    total = 0;
    bad   = 0;
    m_valid = 0;
    idle();
    bus.pc_d = '0;
    bus.pc_e = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 1);
    chk("rst_pred", 32'(bus.pred_taken_d), 0);
    chk("rst_brcnt", bus.branch_cnt, 0);
    cyc();
    rst_n = 1;
    busy_len("init_len");

    // all entries weakly not taken after init
    for (int i = 0; i < 64; i++) begin
      cyc();
      bus.pc_d = 32'(i * 4);
      @(negedge clk);
      chk("init_pred", 32'(bus.pred_taken_d), 0);
    end

    // training beq at 0x100, three taken updates
    cyc();
    br(3'd0, 1, 0, 0, 0, 32'h100);
    bus.pc_d = 32'h100;
    @(negedge clk);
    chk("tr_pcsrc", 32'(bus.pc_src), 1);
    chk("tr_flush", 32'(bus.flush_de), 1);
    chk("tr_pred0", 32'(bus.pred_taken_d), 0);
    cyc();
    @(negedge clk);
    chk("tr_pred1", 32'(bus.pred_taken_d), 1);
    cyc();
    cyc();
    idle();
    @(negedge clk);
    chk("tr_brcnt", bus.branch_cnt, 3);
    chk("tr_miscnt", bus.mispred_cnt, 3);
    chk("tr_pred3", 32'(bus.pred_taken_d), 1);

    // recovery: bgeu not taken but predicted taken, twice
    cyc();
    br(3'd7, 0, 1, 1, 1, 32'h100);
    @(negedge clk);
    chk("rc_pcsrc", 32'(bus.pc_src), 3);
    chk("rc_flush", 32'(bus.flush_de), 1);
    cyc();
    idle();
    @(negedge clk);
    chk("rc_miscnt", bus.mispred_cnt, 4);
    chk("rc_pred", 32'(bus.pred_taken_d), 1);
    cyc();
    br(3'd7, 0, 1, 1, 1, 32'h100);
    cyc();
    idle();
    @(negedge clk);
    chk("rc_pred2", 32'(bus.pred_taken_d), 0);
    chk("rc_brcnt", bus.branch_cnt, 5);

    // jalr wins over a branch; jal alone
    cyc();
    br(3'd0, 1, 0, 0, 1, 32'h308);
    bus.jalr_e = 1;
    @(negedge clk);
    chk("pr_jalr", 32'(bus.pc_src), 2);
    cyc();
    idle();
    bus.jump_e = 1;
    @(negedge clk);
    chk("pr_jal", 32'(bus.pc_src), 1);
    cyc();
    idle();
    @(negedge clk);
    chk("pr_brcnt", bus.branch_cnt, 6);
    chk("pr_miscnt", bus.mispred_cnt, 5);

    // illegal func3
    cyc();
    br(3'd2, 1, 1, 1, 0, 32'h30C);
    @(negedge clk);
    chk("il_flag", 32'(bus.illegal_br), 1);
    chk("il_pcsrc", 32'(bus.pc_src), 0);
    cyc();
    idle();
    @(negedge clk);
    chk("il_brcnt", bus.branch_cnt, 6);

    // stalled branch neither trains nor counts
    cyc();
    br(3'd0, 1, 0, 0, 0, 32'h30C);
    bus.stall_e = 1;
    cyc();
    idle();
    bus.pc_d = 32'h30C;
    @(negedge clk);
    chk("st_brcnt", bus.branch_cnt, 6);
    chk("st_pred", 32'(bus.pred_taken_d), 0);

    // same index read and update: no bypass
    cyc();
    br(3'd0, 1, 0, 0, 0, 32'h204);
    bus.pc_d = 32'h204;
    @(negedge clk);
    chk("si_pred0", 32'(bus.pred_taken_d), 0);
    cyc();
    idle();
    @(negedge clk);
    chk("si_pred1", 32'(bus.pred_taken_d), 1);
    chk("si_brcnt", bus.branch_cnt, 7);

    // decode vectors, predicted not taken
    vecs[0] = '{3'd0, 0, 0, 0, 0};
    vecs[1] = '{3'd1, 0, 0, 0, 1};
    vecs[2] = '{3'd1, 1, 0, 0, 0};
    vecs[3] = '{3'd4, 0, 1, 0, 1};
    vecs[4] = '{3'd5, 0, 1, 0, 0};
    vecs[5] = '{3'd6, 0, 1, 0, 0};
    vecs[6] = '{3'd7, 0, 1, 0, 1};
    vecs[7] = '{3'd6, 0, 0, 1, 1};
    for (int i = 0; i < 8; i++) begin
      cyc();
      br(vecs[i].f, vecs[i].z, vecs[i].l,
         vecs[i].lu, 0, 32'(32'h440 + i * 4));
      @(negedge clk);
      chk("dec_pcsrc", 32'(bus.pc_src),
          vecs[i].tk ? 1 : 0);
    end
    cyc();
    idle();
    @(negedge clk);
    chk("dec_brcnt", bus.branch_cnt, 15);
    chk("dec_miscnt", bus.mispred_cnt, 10);

    // reset in the middle of the init sweep
    cyc();
    rst_n = 0;
    cyc();
    rst_n = 1;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 0;
    cyc();
    rst_n = 1;
    busy_len("mid_len");
    chk("mid_brcnt", bus.branch_cnt, 0);
    chk("mid_miscnt", bus.mispred_cnt, 0);
    cyc();
    bus.pc_d = 32'h100;
    @(negedge clk);
    chk("mid_pred", 32'(bus.pred_taken_d), 0);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
